// File: rtl/intc.sv
// intc: fixed-priority interrupt controller on a rib slave port.
// Define INTC_SYNC_EN to put a 2-flop synchronizer on every irq_src_i bit.
module intc #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    input  logic [NUM_SRC-1:0] irq_src_i,
    output logic [7:0]         int_o
);
    localparam logic [7:0] A_ENABLE  = 8'h00;
    localparam logic [7:0] A_PENDING = 8'h04;
    localparam logic [7:0] A_TRIGGER = 8'h08;
    localparam logic [7:0] A_CLAIM   = 8'h0C;
    localparam logic [7:0] A_CTRL    = 8'h10;

    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] trigger;
    logic [NUM_SRC-1:0] src_prev;
    logic [NUM_SRC-1:0] src_cur;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] pend_nxt;
    logic [NUM_SRC-1:0] active;
    logic               gie;
    logic [7:0]         claim_id;
    logic               wr_enable;
    logic               wr_pending;
    logic               wr_trigger;
    logic               wr_claim;
    logic               wr_ctrl;
    logic               unused_bits;

    assign unused_bits = ^{addr_i[31:8], data_i};

`ifdef INTC_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1;
    logic [NUM_SRC-1:0] sync_q2;

    // Two-stage synchronizer so asynchronous sources are safe to sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_src_i;
            sync_q2 <= sync_q1;
        end
    end

    assign src_cur = sync_q2;
`else
    assign src_cur = irq_src_i;
`endif

    assign wr_enable  = we_i && (addr_i[7:0] == A_ENABLE);
    assign wr_pending = we_i && (addr_i[7:0] == A_PENDING);
    assign wr_trigger = we_i && (addr_i[7:0] == A_TRIGGER);
    assign wr_claim   = we_i && (addr_i[7:0] == A_CLAIM);
    assign wr_ctrl    = we_i && (addr_i[7:0] == A_CTRL);

    assign rise   = src_cur & ~src_prev;
    assign active = pending & enable;

    // Clear requests from W1C or completion; only edge-mode bits honour them.
    always_comb begin
        clr = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (wr_pending && data_i[k]) begin
                clr[k] = 1'b1;
            end
            if (wr_claim && (data_i[7:0] == 8'(k + 1))) begin
                clr[k] = 1'b1;
            end
        end
        clr = clr & trigger;
    end

    // Edge bits: a new rise beats a clear; level bits simply follow the source.
    always_comb begin
        pend_nxt = (trigger & ((pending & ~clr) | rise))
                 | (~trigger & src_cur);
    end

    // Lowest-index active source wins; ID is index+1, 0 means none.
    always_comb begin
        claim_id = 8'd0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (active[k]) begin
                claim_id = 8'(k + 1);
            end
        end
    end

    // Register file, pending state, edge history and the registered ID to the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable   <= '0;
            trigger  <= '0;
            pending  <= '0;
            src_prev <= '0;
            gie      <= 1'b0;
            int_o    <= 8'd0;
        end else begin
            src_prev <= src_cur;
            pending  <= pend_nxt;
            int_o    <= gie ? claim_id : 8'd0;
            if (wr_enable) begin
                enable <= data_i[NUM_SRC-1:0];
            end
            if (wr_trigger) begin
                trigger <= data_i[NUM_SRC-1:0];
            end
            if (wr_ctrl) begin
                gie <= data_i[0];
            end
        end
    end

    // Side-effect-free read mux; unmapped offsets read 0.
    always_comb begin
        case (addr_i[7:0])
            A_ENABLE:  data_o = 32'(enable);
            A_PENDING: data_o = 32'(pending);
            A_TRIGGER: data_o = 32'(trigger);
            A_CLAIM:   data_o = 32'(claim_id);
            A_CTRL:    data_o = {31'd0, gie};
            default:   data_o = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_intc.sv
// tb_intc: directed and randomized checks of intc against a behavioural model.
// Built with INTC_SYNC_EN undefined.
module tb_intc;
    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [7:0]  src;
    logic [7:0]  int_o;

    int n_cmp;
    int n_bad;

    bit [7:0] m_en;
    bit [7:0] m_trig;
    bit [7:0] m_pend;
    bit [7:0] m_prev;
    bit [7:0] m_int;
    bit       m_gie;

    intc #(.NUM_SRC(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we),
        .addr_i   (addr),
        .data_i   (data),
        .data_o   (rdata),
        .irq_src_i(src),
        .int_o    (int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input bit [7:0] v);
        for (int k = 0; k < 8; k++) begin
            if (v[k]) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit [31:0] mread(input bit [7:0] a);
        case (a)
            8'h00:   return {24'd0, m_en};
            8'h04:   return {24'd0, m_pend};
            8'h08:   return {24'd0, m_trig};
            8'h0C:   return 32'(winner(m_pend & m_en));
            8'h10:   return {31'd0, m_gie};
            default: return 32'd0;
        endcase
    endfunction

    // One clock: model the next state from current inputs, then advance.
    task automatic tick();
        bit [7:0] np;
        bit [7:0] ne;
        bit [7:0] nt;
        bit [7:0] ni;
        bit [7:0] npv;
        bit       ng;
        bit [7:0] a;
        a = addr[7:0];
        if (rst) begin
            np = 0; ne = 0; nt = 0; ni = 0; npv = 0; ng = 0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (m_trig[k]) begin
                    bit hit;
                    hit = we && ((a == 8'h04 && data[k]) ||
                                 (a == 8'h0C && data[7:0] == 8'(k + 1)));
                    np[k] = (src[k] && !m_prev[k]) || (m_pend[k] && !hit);
                end else begin
                    np[k] = src[k];
                end
            end
            ni  = m_gie ? 8'(winner(m_pend & m_en)) : 8'd0;
            ne  = m_en;
            nt  = m_trig;
            ng  = m_gie;
            npv = src;
            if (we) begin
                case (a)
                    8'h00:   ne = data[7:0];
                    8'h08:   nt = data[7:0];
                    8'h10:   ng = data[0];
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
        m_pend = np; m_en = ne; m_trig = nt;
        m_int = ni; m_prev = npv; m_gie = ng;
    endtask

    task automatic wr(input bit [31:0] a, input bit [31:0] d);
        we = 1'b1; addr = a; data = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input bit [31:0] a,
                      input bit [31:0] exp);
        we = 1'b0; addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        bit [7:0] alist [6];
        n_cmp = 0; n_bad = 0;
        m_en = 0; m_trig = 0; m_pend = 0; m_prev = 0; m_int = 0; m_gie = 0;
        alist = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
        rst = 1'b1; we = 1'b0; addr = 0; data = 0; src = 8'hFF;

        tick(); tick();
        chk("rst_int", int_o, 0);
        rd("rst_en", 32'h00, 0);
        rd("rst_pend", 32'h04, 0);
        rd("rst_trig", 32'h08, 0);
        rd("rst_claim", 32'h0C, 0);
        rd("rst_ctrl", 32'h10, 0);
        src = 8'h00; rst = 1'b0;
        tick();
        rd("post_rst_pend", 32'h04, 0);

        wr(32'h00, 32'h08); wr(32'h08, 32'h08); wr(32'h10, 32'h1);
        src = 8'h08; tick(); src = 8'h00;
        rd("edge_pend", 32'h04, 32'h08);
        chk("edge_int1", int_o, 0);
        tick();
        chk("edge_int2", int_o, 4);
        wr(32'h0C, 32'h4);
        rd("edge_cmpl_pend", 32'h04, 0);
        chk("edge_cmpl_int_hold", int_o, 4);
        tick();
        chk("edge_cmpl_int", int_o, 0);

        wr(32'h08, 32'hFF); wr(32'h00, 32'hFF);
        src = 8'h22; tick(); src = 8'h00; tick();
        rd("prio_claim2", 32'h0C, 2);
        chk("prio_int2", int_o, 2);
        wr(32'h0C, 32'h2);
        rd("prio_claim6", 32'h0C, 6);
        tick();
        chk("prio_int6", int_o, 6);
        wr(32'h0C, 32'h6); tick();
        chk("prio_int0", int_o, 0);

        wr(32'h08, 32'hFB);
        src = 8'h04; tick(); tick();
        rd("lvl_pend", 32'h04, 32'h04);
        wr(32'h0C, 32'h3);
        rd("lvl_cmpl", 32'h04, 32'h04);
        wr(32'h04, 32'h4);
        rd("lvl_w1c", 32'h04, 32'h04);
        src = 8'h00; tick();
        rd("lvl_drop", 32'h04, 0);
        tick(); tick();

        we = 1'b1; addr = 32'h04; data = 32'h1; src = 8'h01;
        tick();
        we = 1'b0; src = 8'h00;
        rd("coll_pend", 32'h04, 32'h01);
        wr(32'h04, 32'h1);
        rd("coll_w1c", 32'h04, 0);
        tick(); tick();

        wr(32'h00, 32'h0);
        src = 8'h10; tick(); src = 8'h00; tick(); tick();
        chk("mask_int0", int_o, 0);
        rd("mask_claim0", 32'h0C, 0);
        rd("mask_pend", 32'h04, 32'h10);
        wr(32'h00, 32'h10);
        chk("mask_int_hold", int_o, 0);
        tick();
        chk("mask_int5", int_o, 5);
        wr(32'h10, 32'h0);
        chk("gie_int_hold", int_o, 5);
        tick();
        chk("gie_int0", int_o, 0);

        for (int i = 0; i < 600; i++) begin
            bit [31:0] ra;
            ra = {$urandom_range(0, 3) == 0 ? 24'($urandom) : 24'd0,
                  alist[$urandom_range(0, 5)]};
            rd("rand_rd", ra, mread(ra[7:0]));
            rst  = ($urandom_range(0, 79) == 0);
            we   = ($urandom_range(0, 2) == 0);
            addr = {$urandom_range(0, 3) == 0 ? 24'($urandom) : 24'd0,
                    alist[$urandom_range(0, 5)]};
            data = (addr[7:0] == 8'h0C) ? 32'($urandom_range(0, 10))
                                        : $urandom;
            if ($urandom_range(0, 1) == 0) src = 8'($urandom);
            tick();
            chk("rand_int", int_o, 32'(m_int));
        end
        rst = 1'b0; we = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
